// File: rtl/shift_ctrl.sv
// shift_ctrl: multi-cycle shift/rotate sequencer for the datapath ALU.
// One bit position per cycle; result and illegal flag are registered and
// only change on entry to DONE, so the ALU can latch them on done.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; busy=0, done=0; amount decoded here
// ST_SHIFT | work register moves one position per cycle, count decrements
// ST_DONE  | done=1 for one cycle with result/illegal just loaded
module shift_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             illegal_o
);

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  // Shift amounts saturate at the operand width; the count holds 0..32.
  localparam logic [WIDTH-1:0] SAT_AMOUNT = WIDTH'(32);
  localparam logic [5:0]       SAT_COUNT  = 6'd32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] work_q;
  logic [5:0]       cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             illegal_q;

  logic             legal_d;
  logic             rotate_d;
  logic [5:0]       cnt_start_d;
  logic [WIDTH-1:0] step_d;

  // Decode the incoming op and amount into the starting count.
  // Negative amounts and illegal ops both collapse to a zero-length run,
  // which hands the operand straight back as the result.
  always_comb begin
    legal_d     = (op_i <= OP_ROL);
    rotate_d    = (op_i == OP_ROR) || (op_i == OP_ROL);
    cnt_start_d = 6'd0;
    if (legal_d && !b_i[WIDTH-1]) begin
      if (rotate_d) begin
        cnt_start_d = {1'b0, b_i[4:0]};
      end else if (b_i > SAT_AMOUNT) begin
        cnt_start_d = SAT_COUNT;
      end else begin
        cnt_start_d = b_i[5:0];
      end
    end
  end

  // One-position move of the work register for the latched op.
  always_comb begin
    step_d = work_q;
    case (op_q)
      OP_SHR:  step_d = {1'b0, work_q[WIDTH-1:1]};
      OP_SHRA: step_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      OP_SHL:  step_d = {work_q[WIDTH-2:0], 1'b0};
      OP_ROR:  step_d = {work_q[0], work_q[WIDTH-1:1]};
      OP_ROL:  step_d = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      default: step_d = work_q;
    endcase
  end

  // Sequencer FSM with registered busy/done/result/illegal.
  // Reset wins over everything, so an aborted run never produces done.
  always_ff @(posedge clock_i) begin
    if (!clear_i) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_SHR;
      work_q    <= '0;
      cnt_q     <= 6'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            op_q   <= op_i;
            work_q <= a_i;
            busy_q <= 1'b1;
            if (cnt_start_d == 6'd0) begin
              cnt_q     <= 6'd0;
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              result_q  <= a_i;
              illegal_q <= !legal_d;
            end else begin
              cnt_q   <= cnt_start_d;
              state_q <= ST_SHIFT;
            end
          end
        end

        ST_SHIFT: begin
          work_q <= step_d;
          cnt_q  <= cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            result_q  <= step_d;
            // only legal ops ever reach SHIFT
            illegal_q <= 1'b0;
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign result_o  = result_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl: hand-computed results, latencies and
// busy lengths for each op class, amount rules, ignored start and reset.
module tb_shift_ctrl;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'b000;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  shift_ctrl #(.WIDTH(32)) dut (
    .clock_i   (clock),
    .clear_i   (clear),
    .start_i   (start),
    .op_i      (op),
    .a_i       (a),
    .b_i       (b),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result),
    .illegal_o (illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Launch one op, count edges to done (accepting edge counts as 1),
  // count busy cycles, check result hold before done and the result itself.
  task automatic run_op(input string tag, input logic [2:0] op_v, input logic [31:0] a_v,
                        input logic [31:0] b_v, input logic [31:0] exp_res,
                        input logic exp_ill, input int exp_lat);
    int          cyc;
    int          busy_cyc;
    logic        held;
    logic [31:0] prev;
    cyc      = 0;
    busy_cyc = 0;
    held     = 1'b1;
    prev     = result;
    op       = op_v;
    a        = a_v;
    b        = b_v;
    start    = 1'b1;
    while (cyc < 60) begin
      tick();
      start = 1'b0;
      a     = 32'hDEAD_BEEF;
      b     = 32'h0000_0007;
      op    = 3'b010;
      cyc++;
      if (busy) busy_cyc++;
      if (done) break;
      if (result !== prev) held = 1'b0;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, " busy"}, 32'(busy_cyc), 32'(exp_lat));
    chk({tag, " result"}, result, exp_res);
    chk({tag, " illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
    chk({tag, " hold"}, {31'd0, held}, 32'd1);
    tick();
    chk({tag, " idle"}, {30'd0, busy, done}, 32'd0);
    chk({tag, " kept"}, result, exp_res);
  endtask

  initial begin
    int          dones;
    logic [31:0] keep;

    // reset
    clear = 1'b0;
    tick();
    tick();
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst illegal", {31'd0, illegal}, 32'd0);
    clear = 1'b1;
    tick();

    // rotates and amount rules
    run_op("ror4",   3'b011, 32'h0000_00F1, 32'd4,          32'h1000_000F, 1'b0, 5);
    run_op("ror36",  3'b011, 32'h0000_00F1, 32'd36,         32'h1000_000F, 1'b0, 5);
    run_op("rorneg", 3'b011, 32'h0000_00F1, 32'h8000_0004,  32'h0000_00F1, 1'b0, 1);
    run_op("ror32",  3'b011, 32'hA5A5_0001, 32'd32,         32'hA5A5_0001, 1'b0, 1);

    // shift saturation
    run_op("shra40", 3'b001, 32'h8000_0000, 32'd40,         32'hFFFF_FFFF, 1'b0, 33);
    run_op("shr40",  3'b000, 32'h8000_0000, 32'd40,         32'h0000_0000, 1'b0, 33);
    run_op("shl31",  3'b010, 32'h0000_0001, 32'd31,         32'h8000_0000, 1'b0, 32);
    run_op("shr3",   3'b000, 32'hF000_0010, 32'd3,          32'h1E00_0002, 1'b0, 4);
    run_op("shlneg", 3'b010, 32'h0000_0001, 32'hFFFF_FFFF,  32'h0000_0001, 1'b0, 1);

    // ROL with a start during SHIFT and during DONE that must be ignored
    op    = 3'b100;
    a     = 32'h8000_0001;
    b     = 32'd1;
    start = 1'b1;
    tick();
    a     = 32'h1111_0000;
    op    = 3'b010;
    b     = 32'd3;
    chk("rol busy", {31'd0, busy}, 32'd1);
    tick();
    chk("rol done", {31'd0, done}, 32'd1);
    chk("rol result", result, 32'h0000_0003);
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) dones++;
      tick();
    end
    chk("rol no 2nd op", 32'(dones), 32'd0);
    chk("rol unchanged", result, 32'h0000_0003);

    // illegal op, then a legal op clears the flag
    run_op("ill",    3'b111, 32'h1234_5678, 32'd5,          32'h1234_5678, 1'b1, 1);
    run_op("ill101", 3'b101, 32'hCAFE_F00D, 32'd2,          32'hCAFE_F00D, 1'b1, 1);
    run_op("rol2",   3'b100, 32'hC000_0000, 32'd2,          32'h0000_0003, 1'b0, 3);

    // reset in the 3rd SHIFT cycle of a SHL by 20
    op    = 3'b010;
    a     = 32'h0000_0001;
    b     = 32'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    clear = 1'b0;
    tick();
    clear = 1'b1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort illegal", {31'd0, illegal}, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) dones++;
    end
    chk("abort no done", 32'(dones), 32'd0);
    keep = result;
    chk("abort keep", keep, 32'd0);
    run_op("post",   3'b010, 32'h0000_0001, 32'd20,         32'h0010_0000, 1'b0, 21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
